// File: rtl/fb_pkg.sv
// Shared framebuffer definitions used by the swap scheduler, the framebuffer
// memory and the VGA timing blocks.
package fb_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int FB_WORDS  = 76800;

  typedef logic [7:0] rgb332_t;

  typedef enum logic [1:0] {
    CLEAR,
    RENDER,
    WAIT_VB,
    SWAP
  } fb_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Walks the back buffer from address 0 to FB_WORDS-1, one fill word per cycle,
// while active and enabled; dropping enable aborts the walk and rewinds it.
module fb_clear_engine #(
  parameter int         FB_WORDS    = fb_pkg::FB_WORDS,
  parameter int         ADDR_W      = 20,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              enable,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              done
);
  import fb_pkg::*;

  localparam rgb332_t FILL = CLEAR_COLOR;

  logic [ADDR_W-1:0] count;
  logic              last;

  assign last = (count == ADDR_W'(FB_WORDS - 1));
  assign we   = active && enable;
  assign addr = we ? count : '0;
  assign data = we ? FILL : 8'h00;
  assign done = active && (!enable || last);

  // Any cycle that is not a non-final write rewinds, so the next clear starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (we && !last) begin
      count <= count + ADDR_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Ping-pong framebuffer sequencer: clears the back buffer, lets the renderer
// draw into it, and swaps front/back only at the start of vertical blanking.
module fb_swap_scheduler #(
  parameter int         H_VISIBLE   = fb_pkg::H_VISIBLE,
  parameter int         V_VISIBLE   = fb_pkg::V_VISIBLE,
  parameter int         FB_WORDS    = fb_pkg::FB_WORDS,
  parameter int         ADDR_W      = 20,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              clear_en,
  input  logic              render_done,
  input  logic [ADDR_W-1:0] ren_addr,
  input  logic [7:0]        ren_data,
  input  logic              ren_we,
  output logic              render_go,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_we,
  output logic              front_sel,
  output logic [15:0]       frame_count,
  output logic [7:0]        missed_frames
);
  import fb_pkg::*;

  fb_state_t         state, state_next;
  logic [9:0]        vc_q;
  logic              vb_armed;
  logic              vblank;
  logic              clear_active, clear_we, clear_done;
  logic [ADDR_W-1:0] clear_addr;
  rgb332_t           clear_data;
  logic              unused_ok;

  // Horizontal position is only meaningful to the VGA block.
  assign unused_ok = ^{hc, 10'(H_VISIBLE)};

  assign vblank = (vc == 10'(V_VISIBLE)) && (vc_q != 10'(V_VISIBLE));

  // Keep the write port silent while reset is held, even though state sits in CLEAR.
  assign clear_active = (state == CLEAR) && rst;

  fb_clear_engine #(
    .FB_WORDS   (FB_WORDS),
    .ADDR_W     (ADDR_W),
    .CLEAR_COLOR(CLEAR_COLOR)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .active(clear_active),
    .enable(clear_en),
    .we    (clear_we),
    .addr  (clear_addr),
    .data  (clear_data),
    .done  (clear_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // vb_armed makes WAIT_VB ignore a vblank that coincides with its first cycle.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clear_done) state_next = RENDER;
      RENDER:  if (render_done) state_next = WAIT_VB;
      WAIT_VB: if (vblank && vb_armed) state_next = SWAP;
      SWAP:    state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    wr_we   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      CLEAR: begin
        wr_we   = clear_we;
        wr_addr = clear_addr;
        wr_data = clear_data;
      end
      RENDER: begin
        wr_we   = ren_we;
        wr_addr = ren_addr;
        wr_data = ren_data;
      end
      default: ;
    endcase
  end

  // The swap is committed on the vblank cycle so it is visible during SWAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc_q          <= '0;
      vb_armed      <= 1'b0;
      render_go     <= 1'b0;
      front_sel     <= 1'b0;
      frame_count   <= '0;
      missed_frames <= '0;
    end else begin
      vc_q      <= vc;
      vb_armed  <= (state == WAIT_VB);
      render_go <= (state == CLEAR) && (state_next == RENDER);
      if ((state == WAIT_VB) && (state_next == SWAP)) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + 16'd1;
      end
      if (vblank && ((state == CLEAR) || (state == RENDER)) && (missed_frames != 8'hFF)) begin
        missed_frames <= missed_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Self-checking bench for fb_swap_scheduler: a vector table for the first
// frame, hand sequences for the multi-cycle corners, then random traffic vs a model.
module tb_fb_swap_scheduler;

  localparam int         FBW = 16;
  localparam int         AW  = 20;
  localparam int         VV  = 480;
  localparam logic [7:0] CC  = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    hc = '0, vc = '0;
  logic          clear_en = 1'b0, render_done = 1'b0, ren_we = 1'b0;
  logic [AW-1:0] ren_addr = '0;
  logic [7:0]    ren_data = '0;
  logic          render_go, wr_we, front_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [15:0]   frame_count;
  logic [7:0]    missed_frames;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  fb_swap_scheduler #(
    .H_VISIBLE  (640),
    .V_VISIBLE  (VV),
    .FB_WORDS   (FBW),
    .ADDR_W     (AW),
    .CLEAR_COLOR(CC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hc           (hc),
    .vc           (vc),
    .clear_en     (clear_en),
    .render_done  (render_done),
    .ren_addr     (ren_addr),
    .ren_data     (ren_data),
    .ren_we       (ren_we),
    .render_go    (render_go),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_we        (wr_we),
    .front_sel    (front_sel),
    .frame_count  (frame_count),
    .missed_frames(missed_frames)
  );

  typedef struct {
    logic          rst;
    logic [9:0]    vc;
    logic          ce, rd, rwe;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    logic          e_go, e_front;
    logic [15:0]   e_fc;
    logic [7:0]    e_missed;
    logic          chk_ad;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input int v, input logic ce, rd, rwe,
                        input int ra, input int rdt, input logic ewe, input int ea,
                        input int ed, input logic ego, efr, input int efc, emiss,
                        input logic chk);
    vec_t t;
    t.rst = r; t.vc = 10'(v); t.ce = ce; t.rd = rd; t.rwe = rwe;
    t.raddr = AW'(ra); t.rdata = 8'(rdt);
    t.e_we = ewe; t.e_addr = AW'(ea); t.e_data = 8'(ed);
    t.e_go = ego; t.e_front = efr; t.e_fc = 16'(efc); t.e_missed = 8'(emiss);
    t.chk_ad = chk;
    vecs.push_back(t);
  endtask

  // Drives one cycle's inputs just after the rising edge and returns at the falling edge.
  task automatic applyStimulus(input logic r, input logic [9:0] v, input logic ce, rd, rwe,
                               input logic [AW-1:0] ra, input logic [7:0] rdt);
    @(posedge clk);
    #1;
    rst = r; vc = v; clear_en = ce; render_done = rd; ren_we = rwe;
    ren_addr = ra; ren_data = rdt; hc = 10'($urandom_range(0, 799));
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic we, go, front, input logic [15:0] fc,
                                       input logic [7:0] ms, input logic [AW-1:0] a,
                                       input logic [7:0] d, input logic chk);
    return {9'b0, we, go, front, fc, ms, chk ? a : 20'd0, chk ? d : 8'd0};
  endfunction

  // Reference model: phases 0 clearing, 1 drawing, 2 waiting for vblank, 3 swapping.
  int         m_phase, m_idx, m_wait_age, m_frames, m_missed;
  logic       m_go, m_front;
  logic [9:0] m_vc_prev;
  logic       e_we, e_go, e_front, e_chk;
  logic [AW-1:0] e_addr;
  logic [7:0] e_data, e_missed;
  logic [15:0] e_fc;

  task automatic modelReset();
    m_phase = 0; m_idx = 0; m_wait_age = 0; m_frames = 0; m_missed = 0;
    m_go = 1'b0; m_front = 1'b0; m_vc_prev = '0;
  endtask

  task automatic modelCycle(input logic [9:0] v, input logic ce, rd, rwe,
                            input logic [AW-1:0] ra, input logic [7:0] rdt);
    bit ev;
    int next;
    logic go_next;
    ev = (v == 10'(VV)) && (m_vc_prev != 10'(VV));
    e_go = m_go; e_front = m_front; e_fc = 16'(m_frames); e_missed = 8'(m_missed);
    e_we = 1'b0; e_addr = '0; e_data = '0; e_chk = 1'b0;
    next = m_phase; go_next = 1'b0;
    if (m_phase == 0) begin
      if (ce) begin e_we = 1'b1; e_addr = AW'(m_idx); e_data = CC; e_chk = 1'b1; end
      if (!ce || m_idx == FBW - 1) begin next = 1; go_next = 1'b1; m_idx = 0; end
      else m_idx++;
    end else if (m_phase == 1) begin
      e_we = rwe; e_addr = ra; e_data = rdt; e_chk = 1'b1;
      if (rd) next = 2;
    end else if (m_phase == 2) begin
      if (ev && m_wait_age >= 1) begin
        next = 3; m_front = ~m_front; m_frames = (m_frames + 1) % 65536;
      end
    end else begin
      next = 0;
    end
    if (ev && (m_phase == 0 || m_phase == 1) && m_missed < 255) m_missed++;
    m_wait_age = (m_phase == 2) ? m_wait_age + 1 : 0;
    m_vc_prev = v; m_go = go_next; m_phase = next;
  endtask

  initial begin
    bit seen;
    logic [9:0] r_vc;
    logic r_ce, r_rd, r_we;
    logic [AW-1:0] r_a;
    logic [7:0] r_d;

    #2 rst = 1'b0;

    // First frame: reset, 16-word clear, render passthrough, drop in WAIT_VB, swap.
    addVec(0, 0, 1, 0, 0, 0, 0,        0, 0, 0,       0, 0, 0, 0, 1);
    for (int i = 0; i < FBW; i++)
      addVec(1, 0, 1, 0, 0, 0, 0,      1, i, 0,       0, 0, 0, 0, 1);
    addVec(1, 0, 1, 0, 1, 5, 8'hE0,    1, 5, 8'hE0,   1, 0, 0, 0, 1);
    addVec(1, 0, 1, 0, 0, 9, 8'h33,    0, 9, 8'h33,   0, 0, 0, 0, 1);
    addVec(1, 0, 1, 1, 1, 5, 8'hE0,    1, 5, 8'hE0,   0, 0, 0, 0, 1);
    addVec(1, 0, 1, 0, 1, 5, 8'hE0,    0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 479, 1, 0, 1, 5, 8'hE0,  0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 480, 1, 0, 0, 0, 0,      0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 480, 1, 0, 0, 0, 0,      0, 0, 0,       0, 1, 1, 0, 0);
    addVec(1, 480, 1, 0, 0, 0, 0,      1, 0, 0,       0, 1, 1, 0, 1);
    addVec(1, 480, 1, 0, 0, 0, 0,      1, 1, 0,       0, 1, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vc, vecs[i].ce, vecs[i].rd, vecs[i].rwe,
                    vecs[i].raddr, vecs[i].rdata);
      checkOutput($sformatf("vec%0d.wr_we", i), 64'(wr_we), 64'(vecs[i].e_we));
      checkOutput($sformatf("vec%0d.render_go", i), 64'(render_go), 64'(vecs[i].e_go));
      checkOutput($sformatf("vec%0d.front_sel", i), 64'(front_sel), 64'(vecs[i].e_front));
      checkOutput($sformatf("vec%0d.frame_count", i), 64'(frame_count), 64'(vecs[i].e_fc));
      checkOutput($sformatf("vec%0d.missed", i), 64'(missed_frames), 64'(vecs[i].e_missed));
      if (vecs[i].chk_ad) begin
        checkOutput($sformatf("vec%0d.wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_addr));
        checkOutput($sformatf("vec%0d.wr_data", i), 64'(wr_data), 64'(vecs[i].e_data));
      end
    end

    // Three vblanks with no render_done are all missed and never swap.
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 479, 1, 0, 0, 0, 0);
      if (k > 0) checkOutput($sformatf("A.missed%0d", k), 64'(missed_frames), 64'(k));
      applyStimulus(1, 479, 1, 0, 0, 0, 0);
      applyStimulus(1, 479, 1, 0, 0, 0, 0);
      applyStimulus(1, 480, 1, 0, 0, 0, 0);
    end
    applyStimulus(1, 480, 1, 0, 0, 0, 0);
    checkOutput("A.missed", 64'(missed_frames), 64'd3);
    checkOutput("A.front_sel", 64'(front_sel), 64'd0);
    checkOutput("A.frame_count", 64'(frame_count), 64'd0);

    // render_done coinciding with vblank: that vblank is missed, the next one swaps.
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      applyStimulus(1, 479, 1, 0, 0, 0, 0);
      if (render_go) seen = 1'b1;
    end
    checkOutput("B.render_go_seen", 64'(seen), 64'd1);
    applyStimulus(1, 480, 1, 1, 0, 0, 0);
    applyStimulus(1, 480, 1, 0, 0, 0, 0);
    checkOutput("B.missed", 64'(missed_frames), 64'd4);
    checkOutput("B.front_early", 64'(front_sel), 64'd0);
    repeat (3) applyStimulus(1, 480, 1, 0, 0, 0, 0);
    checkOutput("B.no_swap", 64'(front_sel), 64'd0);
    applyStimulus(1, 479, 1, 0, 0, 0, 0);
    applyStimulus(1, 480, 1, 0, 0, 0, 0);
    checkOutput("B.front_at_vb", 64'(front_sel), 64'd0);
    applyStimulus(1, 480, 1, 0, 0, 0, 0);
    checkOutput("B.front_after", 64'(front_sel), 64'd1);
    checkOutput("B.frame_count", 64'(frame_count), 64'd1);
    checkOutput("B.missed_hold", 64'(missed_frames), 64'd4);
    checkOutput("B.swap_quiet", 64'(wr_we), 64'd0);

    // Reset asserted when the clear counter reaches 7.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 480, 1, 0, 0, 0, 0);
      checkOutput($sformatf("C.addr%0d", i), 64'({wr_we, wr_addr}), 64'({1'b1, AW'(i)}));
    end
    rst = 1'b0;
    #1;
    checkOutput("C.rst_outputs",
                pack(wr_we, render_go, front_sel, frame_count, missed_frames, wr_addr, wr_data, 1'b1),
                64'd0);
    applyStimulus(1, 479, 1, 0, 0, 0, 0);
    checkOutput("C.restart0", 64'({wr_we, wr_addr, wr_data}), 64'({1'b1, AW'(0), 8'h00}));
    applyStimulus(1, 479, 1, 0, 0, 0, 0);
    checkOutput("C.restart1", 64'({wr_we, wr_addr}), 64'({1'b1, AW'(1)}));

    // Missed-frame counter saturates.
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 262; k++) begin
      applyStimulus(1, 479, 1, 0, 0, 0, 0);
      applyStimulus(1, 480, 1, 0, 0, 0, 0);
    end
    applyStimulus(1, 479, 1, 0, 0, 0, 0);
    checkOutput("D.missed_sat", 64'(missed_frames), 64'd255);
    checkOutput("D.front_sel", 64'(front_sel), 64'd0);

    // Random traffic against the reference model.
    applyStimulus(0, 479, 1, 0, 0, 0, 0);
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      r_vc = 10'(478 + $urandom_range(0, 3));
      r_ce = ($urandom_range(0, 99) < 85);
      r_rd = ($urandom_range(0, 99) < 20);
      r_we = 1'($urandom_range(0, 1));
      r_a  = AW'($urandom());
      r_d  = 8'($urandom());
      applyStimulus(1, r_vc, r_ce, r_rd, r_we, r_a, r_d);
      modelCycle(r_vc, r_ce, r_rd, r_we, r_a, r_d);
      checkOutput($sformatf("rand%0d", c),
                  pack(wr_we, render_go, front_sel, frame_count, missed_frames, wr_addr, wr_data, e_chk),
                  pack(e_we, e_go, e_front, e_fc, e_missed, e_addr, e_data, e_chk));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fb_swap_scheduler.md
# fb_swap_scheduler

Sequences the ping-pong framebuffer that sits between the graphics renderer and the VGA scan-out. It decides which buffer is front (displayed) and which is back (drawn). It clears the back buffer before each frame and hands the back-buffer write port to the renderer with a go/done handshake. It swaps buffers only at the start of vertical blanking, so scan-out never tears.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line in `hc` units.
- `V_VISIBLE`, 480, visible lines; blanking starts when `vc` reaches this value.
- `FB_WORDS`, 76800, words per buffer (320×240, RGB332).
- `ADDR_W`, 20, framebuffer address width.
- `CLEAR_COLOR`, 8'h00, RGB332 value written during a clear.

Ports:
- `clk` in 1: pixel/system clock.
- `rst` in 1: asynchronous, active-low reset.
- `hc`, `vc` in 10 each: scan counters from the VGA timing generator.
- `clear_en` in 1: 1 = clear the back buffer before each frame.
- `render_done` in 1: renderer finished the current frame (level or pulse).
- `ren_addr` in ADDR_W, `ren_data` in 8, `ren_we` in 1: renderer write request.
- `render_go` out 1: one-cycle pulse, renderer may start drawing.
- `wr_addr` out ADDR_W, `wr_data` out 8, `wr_we` out 1: arbitrated back-buffer write port.
- `front_sel` out 1: buffer being scanned out. The back buffer is `~front_sel`.
- `frame_count` out 16: number of completed swaps, wrapping.
- `missed_frames` out 8: count of blanking intervals with no swap, saturating at 255.

## Operation
- States: CLEAR, RENDER, WAIT_VB, SWAP.
- Reset:
  - state enters CLEAR with clear counter 0.
  - `front_sel`=0, `render_go`=0, `wr_we`=0, `wr_addr`=0, `wr_data`=0.
  - `frame_count`=0, `missed_frames`=0.
- CLEAR:
  - If `clear_en`=1, write one word per cycle: `wr_we`=1, `wr_addr`=counter, `wr_data`=CLEAR_COLOR.
  - Addresses run 0..FB_WORDS−1. After the last word, go to RENDER.
  - If `clear_en`=0 in any CLEAR cycle, stop writing that cycle and go to RENDER next.
- RENDER:
  - `render_go` is high on the first RENDER cycle only.
  - The write port passes the renderer through combinationally: `wr_*` = `ren_*`.
  - `render_done`=1 sends the state to WAIT_VB.
- WAIT_VB:
  - `wr_we`=0; renderer writes are dropped.
  - On a vblank event, go to SWAP.
- SWAP:
  - Lasts one cycle: toggle `front_sel`, increment `frame_count`, then go to CLEAR.
- `render_done` outside RENDER is ignored.
- `ren_we` outside RENDER never reaches `wr_we`.
- Vblank event: `vc`==V_VISIBLE in this cycle and `vc`!=V_VISIBLE in the previous cycle (registered copy of `vc`).
- Missed frame: a vblank event while in CLEAR or RENDER increments `missed_frames` (saturating). `front_sel` is unchanged.

## Timing
- `render_go` is asserted exactly 1 cycle after the cycle that leaves CLEAR.
- Clear with `clear_en`=1 takes FB_WORDS cycles. The next cycle is the first RENDER cycle.
- WAIT_VB only accepts vblank events from its second cycle onward. If `render_done` and a vblank event fall in the same cycle, the swap waits for the next vblank and that event counts as missed.
- The swap takes effect the cycle after the vblank event is seen.
- A new frame's first write lands no earlier than 2 cycles after the `front_sel` toggle.
- `frame_count` wraps from 65535 to 0.
- `missed_frames` holds at 255.
- Reset asserted mid-clear or mid-render: all state returns to reset values immediately. After release, the block restarts with a clear of buffer 1 (since `front_sel`=0).

## Structure
- Shared package `fb_pkg`:
  - state enum `fb_state_t`
  - RGB332 pixel typedef
  - FB_WORDS, V_VISIBLE and H_VISIBLE constants, shared with the memory and VGA blocks.
- One natural sub-module, `fb_clear_engine`: address counter, start/abort/done, and its write outputs.
- The FSM, vblank detector and write mux stay in the top module.

## Test plan
- Reset, then `clear_en`=1 with FB_WORDS=16:
  - `wr_we` is high for 16 cycles, addresses 0..15, data 8'h00.
  - `render_go` pulses once on the following cycle.
- In RENDER, drive `ren_we`=1, `ren_addr`=5, `ren_data`=8'hE0 → `wr_*` mirrors them in the same cycle. In WAIT_VB, the same stimulus gives `wr_we`=0.
- `render_done` in RENDER, then `vc` steps 479→480:
  - `front_sel` goes 0→1 one cycle later.
  - `frame_count`=1.
  - CLEAR restarts.
- Hold off `render_done` across 3 vblank events → `missed_frames`=3 and `front_sel` stays 0.
- `render_done` and the vblank event in the same cycle → no swap until the next vblank, and `missed_frames` increments.
- Assert `rst` mid-clear (counter=7):
  - All outputs return to reset values at once.
  - After release, the clear restarts at address 0.
